// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-to-decode queue bus; slave is the queue, master drives fetch groups and decode acceptance.
interface fetch_queue_if #(parameter int ENQ_W = 2, parameter int META_W = 32, parameter int PTR_W = 3);
  logic                    flush;
  logic                    f_enq_valid;
  logic [ENQ_W-1:0]        f_enq_mask;
  logic [ENQ_W*32-1:0]     f_enq_pc;
  logic [ENQ_W*32-1:0]     f_enq_instr;
  logic [ENQ_W-1:0]        f_enq_pred_taken;
  logic [ENQ_W*32-1:0]     f_enq_pred_pc;
  logic [ENQ_W*META_W-1:0] f_enq_meta;
  logic                    q_allow_in;
  logic                    q_to_d_valid;
  logic                    d_allow_in;
  logic [31:0]             q_pc;
  logic [31:0]             q_instr;
  logic [31:0]             q_pred_pc;
  logic                    q_pred_taken;
  logic [META_W-1:0]       q_meta;
  logic [PTR_W:0]          q_count;
  logic                    q_empty;
  logic                    q_full;
  modport slave (
    input  flush, f_enq_valid, f_enq_mask, f_enq_pc, f_enq_instr, f_enq_pred_taken, f_enq_pred_pc, f_enq_meta, d_allow_in,
    output q_allow_in, q_to_d_valid, q_pc, q_instr, q_pred_pc, q_pred_taken, q_meta, q_count, q_empty, q_full
  );
  modport master (
    output flush, f_enq_valid, f_enq_mask, f_enq_pc, f_enq_instr, f_enq_pred_taken, f_enq_pred_pc, f_enq_meta, d_allow_in,
    input  q_allow_in, q_to_d_valid, q_pc, q_instr, q_pred_pc, q_pred_taken, q_meta, q_count, q_empty, q_full
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer taking up to ENQ_W fetch slots per cycle (cut after first predicted-taken slot),
// presenting one entry per cycle to decode, with full flush on redirect.
module fetch_queue #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int ENQ_W  = 2,
  parameter int META_W = 32
) (
  input logic clk,
  input logic rst_n,
  fetch_queue_if.slave bus
);
  logic [31:0]       pc_q         [DEPTH];
  logic [31:0]       instr_q      [DEPTH];
  logic [31:0]       pred_pc_q    [DEPTH];
  logic [META_W-1:0] meta_q       [DEPTH];
  logic [DEPTH-1:0]  pred_taken_q;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d, k, wr_k;
  logic              stop, accept, deq, empty;
  always_comb begin
    k    = '0;
    stop = 1'b0;
    for (int i = 0; i < ENQ_W; i++) begin
      if (!stop && bus.f_enq_mask[i]) k = (PTR_W+1)'(i + 1);
      if (!bus.f_enq_mask[i] || bus.f_enq_pred_taken[i]) stop = 1'b1;
    end
    empty   = count_q == '0;
    accept  = bus.f_enq_valid && bus.q_allow_in && !bus.flush;
    deq     = !empty && bus.d_allow_in && !bus.flush;
    wr_k    = accept ? k : '0;
    head_d  = bus.flush ? '0 : head_q + PTR_W'(deq);
    tail_d  = bus.flush ? '0 : tail_q + wr_k[PTR_W-1:0];
    count_d = bus.flush ? '0 : count_q + wr_k - (PTR_W+1)'(deq);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // Payload array needs no reset: empty-queue outputs are masked below.
  always_ff @(posedge clk) begin
    for (int j = 0; j < ENQ_W; j++) begin
      if ((PTR_W+1)'(j) < wr_k) begin
        pc_q[tail_q + PTR_W'(j)]         <= bus.f_enq_pc[j*32 +: 32];
        instr_q[tail_q + PTR_W'(j)]      <= bus.f_enq_instr[j*32 +: 32];
        pred_pc_q[tail_q + PTR_W'(j)]    <= bus.f_enq_pred_pc[j*32 +: 32];
        meta_q[tail_q + PTR_W'(j)]       <= bus.f_enq_meta[j*META_W +: META_W];
        pred_taken_q[tail_q + PTR_W'(j)] <= bus.f_enq_pred_taken[j];
      end
    end
  end
  assign bus.q_allow_in   = count_q <= (PTR_W+1)'(DEPTH - ENQ_W);
  assign bus.q_to_d_valid = !empty;
  assign bus.q_empty      = empty;
  assign bus.q_full       = count_q == (PTR_W+1)'(DEPTH);
  assign bus.q_count      = count_q;
  assign bus.q_pc         = empty ? '0 : pc_q[head_q];
  assign bus.q_instr      = empty ? '0 : instr_q[head_q];
  assign bus.q_pred_pc    = empty ? '0 : pred_pc_q[head_q];
  assign bus.q_meta       = empty ? '0 : meta_q[head_q];
  assign bus.q_pred_taken = empty ? 1'b0 : pred_taken_q[head_q];
endmodule
